// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared constants and helpers for the pipelined carry-lookahead adder.
//   DEFAULT_GROUP : default number of bits resolved per lookahead group/stage
//   nstage()      : pipeline depth for a given operand width and group size
//   width_ok()    : true when the width splits into whole groups
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int DEFAULT_GROUP = 32'd4;

  // Number of lookahead groups, which is also the pipeline depth.
  function automatic int nstage(input int width, input int group);
    return width / group;
  endfunction

  // Elaboration-time sanity check on the width/group split.
  function automatic bit width_ok(input int width, input int group);
    return (group > 32'sd0) && (width >= group) && ((width % group) == 32'sd0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// ---------------------------------------------------------------------------
// cla_group
// Combinational GROUP-bit carry-lookahead slice. Every internal carry is a
// flat sum of products of generate/propagate terms and the group carry-in,
// so no carry ripples from bit to bit inside the group.
// Ports:
//   a, b      in  GROUP  operand bits (b already inverted for subtract)
//   ci        in  1      carry into bit 0 of the group
//   s         out GROUP  sum bits
//   co        out 1      carry out of the top bit of the group
//   c_msb_in  out 1      carry into the top bit of the group
// ---------------------------------------------------------------------------
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [GROUP-1:0] g_s;
  logic [GROUP-1:0] p_s;
  logic [GROUP:0]   c_s;
  logic             term_s;
  logic             pp_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Expanded lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci.
  always_comb begin
    c_s    = {(GROUP+1){1'b0}};
    term_s = 1'b0;
    pp_s   = 1'b0;
    c_s[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      term_s = g_s[i];
      pp_s   = p_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        term_s = term_s | (pp_s & g_s[j]);
        pp_s   = pp_s & p_s[j];
      end
      c_s[i+1] = term_s | (pp_s & ci);
    end
  end

  assign s        = p_s ^ c_s[GROUP-1:0];
  assign co       = c_s[GROUP];
  assign c_msb_in = c_s[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
// Pipelined carry-lookahead adder/subtractor. The operands are split into
// GROUP-bit groups; group k is resolved in pipeline stage k using the carry
// registered by stage k-1. Resolved low sum bits travel forward in delay
// registers while unresolved operand bits travel in skew registers, so all
// WIDTH result bits meet at the output register NSTAGE enabled edges after
// the operation is accepted.
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      asynchronous active-low reset
//   enable    in  1      global advance; 0 freezes every register
//   in_valid  in  1      operands present this cycle
//   sub       in  1      0: x+y+cin, 1: x-y (cin ignored)
//   cin       in  1      carry-in for add mode
//   x, y      in  WIDTH  operands
//   out_valid out 1      r and flags carry a fresh result
//   r         out WIDTH  result (modulo 2^WIDTH)
//   cout      out 1      carry out of the MSB (subtract: 1 = no borrow)
//   ovf       out 1      two's-complement overflow
//   zero      out 1      r == 0
// Outputs hold their previous values while out_valid is 0.
// ---------------------------------------------------------------------------
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32'd16,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGE = nstage(WIDTH, GROUP);

  if (!width_ok(WIDTH, GROUP)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP");
  end

  // Subtract is x + ~y + 1: invert y once at the input and force carry-in.
  logic [WIDTH-1:0] yp_s;
  logic             c0_s;

  assign yp_s = sub ? ~y : y;
  assign c0_s = sub ? 1'b1 : cin;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [GROUP-1:0] a_s;
    logic [GROUP-1:0] b_s;
    logic [GROUP-1:0] s_s;
    logic             ci_s;
    logic             v_s;
    logic             co_s;
    logic             cm_s;

    cla_group #(
      .GROUP(GROUP)
    ) u_group (
      .a        (a_s),
      .b        (b_s),
      .ci       (ci_s),
      .s        (s_s),
      .co       (co_s),
      .c_msb_in (cm_s)
    );

    // Group 0 reads the ports directly; later groups read the lowest
    // still-unresolved bits of the previous stage's skew registers.
    if (k == 0) begin : g_src
      assign a_s  = x[GROUP-1:0];
      assign b_s  = yp_s[GROUP-1:0];
      assign ci_s = c0_s;
      assign v_s  = in_valid;
    end else begin : g_src
      assign a_s  = g_stage[k-1].g_reg.xa_r[GROUP-1:0];
      assign b_s  = g_stage[k-1].g_reg.yb_r[GROUP-1:0];
      assign ci_s = g_stage[k-1].g_reg.carry_r;
      assign v_s  = g_stage[k-1].g_reg.valid_r;
    end

    if (k < NSTAGE - 1) begin : g_reg
      // LO bits of the sum are resolved after this stage; HI operand bits remain.
      localparam int LO = (k + 1) * GROUP;
      localparam int HI = WIDTH - LO;

      logic          valid_r;
      logic          carry_r;
      logic [LO-1:0] sum_r;
      logic [HI-1:0] xa_r;
      logic [HI-1:0] yb_r;
      logic [LO-1:0] sum_nx_s;
      logic [HI-1:0] xa_nx_s;
      logic [HI-1:0] yb_nx_s;

      if (k == 0) begin : g_nx
        assign sum_nx_s = s_s;
        assign xa_nx_s  = x[WIDTH-1:GROUP];
        assign yb_nx_s  = yp_s[WIDTH-1:GROUP];
      end else begin : g_nx
        assign sum_nx_s = {s_s, g_stage[k-1].g_reg.sum_r};
        assign xa_nx_s  = g_stage[k-1].g_reg.xa_r[WIDTH-k*GROUP-1:GROUP];
        assign yb_nx_s  = g_stage[k-1].g_reg.yb_r[WIDTH-k*GROUP-1:GROUP];
      end

      // Stage register: data captures on bubbles too, only valid_r marks them.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_r <= 1'b0;
          carry_r <= 1'b0;
          sum_r   <= {LO{1'b0}};
          xa_r    <= {HI{1'b0}};
          yb_r    <= {HI{1'b0}};
        end else if (enable) begin
          valid_r <= v_s;
          carry_r <= co_s;
          sum_r   <= sum_nx_s;
          xa_r    <= xa_nx_s;
          yb_r    <= yb_nx_s;
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] res_s;

      if (k == 0) begin : g_res
        assign res_s = s_s;
      end else begin : g_res
        assign res_s = {s_s, g_stage[k-1].g_reg.sum_r};
      end

      // Output register: result and flags update only for valid operations,
      // so a bubble leaves the last result visible with out_valid low.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_valid <= 1'b0;
          r         <= {WIDTH{1'b0}};
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (enable) begin
          out_valid <= v_s;
          if (v_s) begin
            r    <= res_s;
            cout <= co_s;
            ovf  <= cm_s ^ co_s;
            zero <= (res_s == {WIDTH{1'b0}});
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three instances (8/4, 16/4, 32/8) share one
// stimulus stream; a behavioural model predicts every output each cycle and
// directed vectors pin the 16-bit results with hand-computed literals.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;

  logic        ov8, co8, of8, z8;
  logic [7:0]  r8;
  logic        ov16, co16, of16, z16;
  logic [15:0] r16;
  logic        ov32, co32, of32, z32;
  logic [31:0] r32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(8), .GROUP(4)) u_dut8 (
    .clk(clk), .reset(rst_n), .enable(enable), .in_valid(in_valid), .sub(sub), .cin(cin),
    .x(x[7:0]), .y(y[7:0]), .out_valid(ov8), .r(r8), .cout(co8), .ovf(of8), .zero(z8));

  cla_pipe_adder u_dut16 (
    .clk(clk), .reset(rst_n), .enable(enable), .in_valid(in_valid), .sub(sub), .cin(cin),
    .x(x[15:0]), .y(y[15:0]), .out_valid(ov16), .r(r16), .cout(co16), .ovf(of16), .zero(z16));

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (
    .clk(clk), .reset(rst_n), .enable(enable), .in_valid(in_valid), .sub(sub), .cin(cin),
    .x(x), .y(y), .out_valid(ov32), .r(r32), .cout(co32), .ovf(of32), .zero(z32));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sub;
    logic        cin;
    int          acc;
  } op_t;

  typedef struct packed {
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  localparam int WD  [3] = '{8, 16, 32};
  localparam int LAT [3] = '{2, 4, 4};

  op_t         ops[$];
  int          cnt = 0;
  int          nxt [3] = '{0, 0, 0};
  logic        ev  [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] er  [3] = '{32'd0, 32'd0, 32'd0};
  logic        ec  [3] = '{1'b0, 1'b0, 1'b0};
  logic        eo  [3] = '{1'b0, 1'b0, 1'b0};
  logic        ez  [3] = '{1'b0, 1'b0, 1'b0};

  // Plain integer arithmetic on w-bit values.
  function automatic res_t calc(input op_t o, input int w);
    longint unsigned mask, xa, yb, s, rr;
    logic sx, sy, sr;
    res_t e;
    mask = (64'd1 << w) - 64'd1;
    xa   = 64'(o.x) & mask;
    yb   = (o.sub ? 64'(~o.y) : 64'(o.y)) & mask;
    s    = xa + yb + (o.sub ? 64'd1 : 64'(o.cin));
    rr   = s & mask;
    sx   = 1'((xa >> (w - 1)) & 64'd1);
    sy   = 1'((yb >> (w - 1)) & 64'd1);
    sr   = 1'((rr >> (w - 1)) & 64'd1);
    e.r  = 32'(rr);
    e.co = 1'((s >> w) & 64'd1);
    e.ov = (sx == sy) && (sr != sx);
    e.z  = (rr == 64'd0);
    return e;
  endfunction

  // One enabled edge: accept the offered operation, retire any that are due.
  task automatic model_step();
    op_t  o;
    res_t e;
    cnt++;
    if (in_valid === 1'b1) begin
      o.x = x; o.y = y; o.sub = sub; o.cin = cin; o.acc = cnt;
      ops.push_back(o);
    end
    for (int d = 0; d < 3; d++) begin
      ev[d] = 1'b0;
      if (nxt[d] < int'(ops.size())) begin
        if (ops[nxt[d]].acc + LAT[d] - 1 == cnt) begin
          e     = calc(ops[nxt[d]], WD[d]);
          ev[d] = 1'b1;
          er[d] = e.r;
          ec[d] = e.co;
          eo[d] = e.ov;
          ez[d] = e.z;
          nxt[d]++;
        end
      end
    end
  endtask

  // Reset discards everything in flight and zeroes the visible outputs.
  always @(negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      nxt[d] = int'(ops.size());
      ev[d] = 1'b0; er[d] = 32'd0; ec[d] = 1'b0; eo[d] = 1'b0; ez[d] = 1'b0;
    end
  end

  // Compare process: every cycle, all outputs of all three instances.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && enable === 1'b1) model_step();
    #1;
    chk("m8_valid",  {31'd0, ov8},  {31'd0, ev[0]});
    chk("m8_r",      {24'd0, r8},   er[0]);
    chk("m8_cout",   {31'd0, co8},  {31'd0, ec[0]});
    chk("m8_ovf",    {31'd0, of8},  {31'd0, eo[0]});
    chk("m8_zero",   {31'd0, z8},   {31'd0, ez[0]});
    chk("m16_valid", {31'd0, ov16}, {31'd0, ev[1]});
    chk("m16_r",     {16'd0, r16},  er[1]);
    chk("m16_cout",  {31'd0, co16}, {31'd0, ec[1]});
    chk("m16_ovf",   {31'd0, of16}, {31'd0, eo[1]});
    chk("m16_zero",  {31'd0, z16},  {31'd0, ez[1]});
    chk("m32_valid", {31'd0, ov32}, {31'd0, ev[2]});
    chk("m32_r",     r32,           er[2]);
    chk("m32_cout",  {31'd0, co32}, {31'd0, ec[2]});
    chk("m32_ovf",   {31'd0, of32}, {31'd0, eo[2]});
    chk("m32_zero",  {31'd0, z32},  {31'd0, ez[2]});
  end

  // ---------------- directed stimulus ----------------
  task automatic check16(input string tag, input logic v, input logic [15:0] er16,
                         input logic c, input logic o, input logic z);
    chk({tag, "_valid"}, {31'd0, ov16}, {31'd0, v});
    chk({tag, "_r"},     {16'd0, r16},  {16'd0, er16});
    chk({tag, "_cout"},  {31'd0, co16}, {31'd0, c});
    chk({tag, "_ovf"},   {31'd0, of16}, {31'd0, o});
    chk({tag, "_zero"},  {31'd0, z16},  {31'd0, z});
  endtask

  // Called at a negedge: one operation, result expected exactly 4 edges later.
  task automatic single_op(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                           input logic s, input logic c, input logic [15:0] er16,
                           input logic ecv, input logic eov, input logic ezv);
    enable = 1'b1; in_valid = 1'b1; x = xv; y = yv; sub = s; cin = c;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check16(tag, 1'b1, er16, ecv, eov, ezv);
    @(posedge clk);
    #1;
    chk({tag, "_next_valid"}, {31'd0, ov16}, 32'd0);
    @(negedge clk);
  endtask

  logic [31:0] sx_t [8] = '{32'h0001_8000, 32'hDEAD_BEEF, 32'h8000_0000, 32'h1111_1111,
                            32'hFFFF_FFFF, 32'h0F0F_F0F0, 32'h7FFF_FFFF, 32'h1234_5678};
  logic [31:0] sy_t [8] = '{32'h0000_8000, 32'h1234_5678, 32'h8000_0000, 32'h2222_2222,
                            32'h0000_0001, 32'hF0F0_0F0F, 32'h0000_0001, 32'h1234_5678};
  logic        ss_t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        sc_t [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        sv_t [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check16("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    single_op("add_basic", 32'h1234, 32'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    single_op("carry_all", 32'hFFFF, 32'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    single_op("add_ovf",   32'h7FFF, 32'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    single_op("sub_borrow",32'h0005, 32'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    single_op("sub_ovf",   32'h8000, 32'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    single_op("sub_cin_ign",32'h0005, 32'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with a bubble in slot 3.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) check16("stream_op0", 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
      if (i == 7) chk("stream_bubble_valid", {31'd0, ov16}, 32'd0);
      enable = 1'b1; in_valid = sv_t[i]; x = sx_t[i]; y = sy_t[i]; sub = ss_t[i]; cin = sc_t[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Stall with two operations in flight; the pulse during the stall is dropped.
    in_valid = 1'b1; sub = 1'b0; cin = 1'b0; x = 32'h00FF; y = 32'h0001;
    @(negedge clk);
    cin = 1'b1; x = 32'h1000; y = 32'h0FFF;
    @(negedge clk);
    enable = 1'b0; in_valid = 1'b1; cin = 1'b0; x = 32'hAAAA; y = 32'h1111;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, ov16}, 32'd0);
    end
    enable = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check16("stall_a", 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check16("stall_b", 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check16("stall_drop", 1'b0, 16'h2000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Asynchronous reset with three operations in flight.
    in_valid = 1'b1; sub = 1'b0; cin = 1'b0; x = 32'h0003; y = 32'h0004;
    @(negedge clk);
    x = 32'h00F0; y = 32'h000F;
    @(negedge clk);
    x = 32'hFFFF; y = 32'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check16("async_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("async_rst_valid8", {31'd0, ov8}, 32'd0);
    chk("async_rst_r8", {24'd0, r8}, 32'd0);
    chk("async_rst_valid32", {31'd0, ov32}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check16("post_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
